// File: rtl/st_to_mm_fifo_csr.sv
// ============================================================================
// Module      : st_to_mm_fifo_csr
// Description : Avalon-ST sink into a parametrised FIFO, drained by an
//               Avalon-MM read slave with DATA/LEVEL/STATUS/CONTROL words.
//               Optional interrupt output enabled by macro ST_FIFO_IRQ_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module st_to_mm_fifo_csr #(
  parameter int DATA_W      = 32,
  parameter int DEPTH_LOG2  = 7,
  parameter int ALMOST_FULL = 120
) (
  input  logic              wrclock,
  input  logic              reset,
  input  logic [DATA_W-1:0] st_data,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [1:0]        mm_address,
  input  logic              mm_read,
  input  logic              mm_write,
  input  logic [31:0]       mm_writedata,
  output logic [31:0]       mm_readdata
`ifdef ST_FIFO_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int                c_DEPTH    = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_FULL_LVL = (DEPTH_LOG2 + 1)'(c_DEPTH);
  localparam logic [DEPTH_LOG2:0] c_AF_LVL   = (DEPTH_LOG2 + 1)'(ALMOST_FULL);
  localparam logic [1:0]        c_A_DATA   = 2'd0;
  localparam logic [1:0]        c_A_LEVEL  = 2'd1;
  localparam logic [1:0]        c_A_STATUS = 2'd2;
  localparam logic [1:0]        c_A_CTRL   = 2'd3;

  logic [DATA_W-1:0]     r_mem [c_DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  r_ovf;
  logic                  r_unf;
  logic [31:0]           r_readdata;

  logic        w_full, w_empty, w_af;
  logic        w_push, w_pop, w_ovf_set, w_unf_set;
  logic        w_stat_wr, w_ctrl_wr, w_flush;
  logic [31:0] w_rdata;

  assign w_full  = (r_level == c_FULL_LVL);
  assign w_empty = (r_level == '0);
  assign w_af    = (r_level >= c_AF_LVL);

  // Ready is held low during reset so no word is accepted before state is clean.
  assign st_ready = !reset && !w_full;

  assign w_push    = st_valid && st_ready;
  assign w_ovf_set = st_valid && !st_ready;
  assign w_pop     = mm_read && (mm_address == c_A_DATA) && !w_empty;
  assign w_unf_set = mm_read && (mm_address == c_A_DATA) && w_empty;
  assign w_stat_wr = mm_write && (mm_address == c_A_STATUS);
  assign w_ctrl_wr = mm_write && (mm_address == c_A_CTRL);
  assign w_flush   = w_ctrl_wr && mm_writedata[0];

`ifdef ST_FIFO_IRQ_EN
  logic r_irq_en;
  logic r_irq;
  logic w_unused;
  assign w_unused = ^{mm_writedata[31:5], mm_writedata[2]};
  assign irq      = r_irq;
`else
  logic w_unused;
  assign w_unused = ^{mm_writedata[31:5], mm_writedata[2:1]};
`endif

  always_comb begin
    w_rdata = '0;
    case (mm_address)
      c_A_DATA:   if (!w_empty) w_rdata[DATA_W-1:0] = r_mem[r_rd_ptr];
      c_A_LEVEL:  w_rdata[DEPTH_LOG2:0] = r_level;
      c_A_STATUS: w_rdata[4:0] = {r_unf, r_ovf, w_af, w_full, w_empty};
      default: begin
`ifdef ST_FIFO_IRQ_EN
        w_rdata[1] = r_irq_en;
`endif
      end
    endcase
  end

  always_ff @(posedge wrclock) begin
    if (w_push) r_mem[r_wr_ptr] <= st_data;
  end

  always_ff @(posedge wrclock) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
      r_readdata <= '0;
`ifdef ST_FIFO_IRQ_EN
      r_irq_en   <= 1'b0;
      r_irq      <= 1'b0;
`endif
    end else begin
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_push, w_pop})
          2'b10:   r_level <= r_level + 1'b1;
          2'b01:   r_level <= r_level - 1'b1;
          default: r_level <= r_level;
        endcase
      end
      // A new event in the same cycle as its write-1-to-clear keeps the flag set.
      r_ovf <= w_ovf_set || (r_ovf && !(w_stat_wr && mm_writedata[3]));
      r_unf <= w_unf_set || (r_unf && !(w_stat_wr && mm_writedata[4]));
      if (mm_read) r_readdata <= w_rdata;
`ifdef ST_FIFO_IRQ_EN
      if (w_ctrl_wr) r_irq_en <= mm_writedata[1];
      r_irq <= r_irq_en && (w_af || r_ovf);
`endif
    end
  end

  assign mm_readdata = r_readdata;

endmodule

`default_nettype wire

// File: tb/tb_st_to_mm_fifo_csr.sv
// Directed bench for st_to_mm_fifo_csr at default parameters (depth 128, almost-full 120).
`default_nettype none

module tb_st_to_mm_fifo_csr;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] st_data;
  logic        st_valid;
  logic        st_ready;
  logic [1:0]  mm_address;
  logic        mm_read;
  logic        mm_write;
  logic [31:0] mm_writedata;
  logic [31:0] mm_readdata;
`ifdef ST_FIFO_IRQ_EN
  logic        irq;
`endif

  int total = 0;
  int bad   = 0;

  st_to_mm_fifo_csr dut (
    .wrclock      (clk),
    .reset        (reset),
    .st_data      (st_data),
    .st_valid     (st_valid),
    .st_ready     (st_ready),
    .mm_address   (mm_address),
    .mm_read      (mm_read),
    .mm_write     (mm_write),
    .mm_writedata (mm_writedata),
    .mm_readdata  (mm_readdata)
`ifdef ST_FIFO_IRQ_EN
    ,
    .irq          (irq)
`endif
  );

  always #5 clk = ~clk;

  // Drive tasks start and end on a falling edge; one rising edge in between.
  task automatic do_push(input logic [31:0] d);
    st_data = d; st_valid = 1'b1;
    @(negedge clk);
    st_valid = 1'b0;
  endtask

  task automatic do_read(input logic [1:0] a, output logic [31:0] d);
    mm_address = a; mm_read = 1'b1;
    @(negedge clk);
    mm_read = 1'b0;
    d = mm_readdata;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    mm_address = a; mm_writedata = d; mm_write = 1'b1;
    @(negedge clk);
    mm_write = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (st_ready !== 1'b0) begin bad++; $display("FAIL rst_ready_low got=%b exp=0", st_ready); end
    total++;
    if (mm_readdata !== 32'h0) begin bad++; $display("FAIL rst_readdata got=%h exp=0", mm_readdata); end
    reset = 1'b0;
    #1;
    total++;
    if (st_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_after got=%b exp=1", st_ready); end
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [31:0] d;
    do_push(32'hA); do_push(32'hB); do_push(32'hC);
    do_read(2'd1, d);
    total++;
    if (d !== 32'd3) begin bad++; $display("FAIL basic_level3 got=%h exp=3", d); end
    do_read(2'd0, d);
    total++;
    if (d !== 32'hA) begin bad++; $display("FAIL basic_pop0 got=%h exp=a", d); end
    do_read(2'd0, d);
    total++;
    if (d !== 32'hB) begin bad++; $display("FAIL basic_pop1 got=%h exp=b", d); end
    do_read(2'd0, d);
    total++;
    if (d !== 32'hC) begin bad++; $display("FAIL basic_pop2 got=%h exp=c", d); end
    do_read(2'd1, d);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL basic_level0 got=%h exp=0", d); end
  endtask

  task automatic test_full();
    logic [31:0] d;
    for (int i = 0; i < 128; i++) do_push(32'h100 + i);
    total++;
    if (st_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", st_ready); end
    do_read(2'd2, d);
    total++;
    if (d !== 32'h06) begin bad++; $display("FAIL full_status got=%h exp=06", d); end
    do_push(32'hDEAD);
    do_read(2'd2, d);
    total++;
    if (d !== 32'h0E) begin bad++; $display("FAIL full_ovf got=%h exp=0e", d); end
    do_write(2'd2, 32'h08);
    do_read(2'd2, d);
    total++;
    if (d !== 32'h06) begin bad++; $display("FAIL full_ovf_clr got=%h exp=06", d); end
    do_read(2'd1, d);
    total++;
    if (d !== 32'h80) begin bad++; $display("FAIL full_level got=%h exp=80", d); end
    do_read(2'd0, d);
    total++;
    if (d !== 32'h100) begin bad++; $display("FAIL full_pop0 got=%h exp=100", d); end
    total++;
    if (st_ready !== 1'b1) begin bad++; $display("FAIL full_ready_freed got=%b exp=1", st_ready); end
    do_read(2'd0, d);
    total++;
    if (d !== 32'h101) begin bad++; $display("FAIL full_pop1 got=%h exp=101", d); end
    do_write(2'd3, 32'h1);
    do_read(2'd2, d);
    total++;
    if (d !== 32'h01) begin bad++; $display("FAIL full_flushed got=%h exp=01", d); end
  endtask

  task automatic test_underflow();
    logic [31:0] d;
    do_push(32'h77);
    do_read(2'd0, d);
    total++;
    if (d !== 32'h77) begin bad++; $display("FAIL unf_prep got=%h exp=77", d); end
    do_read(2'd0, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL unf_data got=%h exp=0", d); end
    do_read(2'd2, d);
    total++;
    if (d !== 32'h11) begin bad++; $display("FAIL unf_status got=%h exp=11", d); end
    do_read(2'd1, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL unf_level got=%h exp=0", d); end
    do_write(2'd2, 32'h10);
    do_read(2'd2, d);
    total++;
    if (d !== 32'h01) begin bad++; $display("FAIL unf_clr got=%h exp=01", d); end
  endtask

  task automatic test_push_pop_same();
    logic [31:0] d;
    for (int i = 0; i < 5; i++) do_push(32'h50 + i);
    st_data = 32'h55; st_valid = 1'b1;
    do_read(2'd0, d);
    st_valid = 1'b0;
    total++;
    if (d !== 32'h50) begin bad++; $display("FAIL pp_head got=%h exp=50", d); end
    do_read(2'd1, d);
    total++;
    if (d !== 32'd5) begin bad++; $display("FAIL pp_level got=%h exp=5", d); end
    for (int i = 1; i < 6; i++) begin
      do_read(2'd0, d);
      total++;
      if (d !== 32'h50 + i) begin bad++; $display("FAIL pp_order%0d got=%h exp=%h", i, d, 32'h50 + i); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    do_push(32'hC000_0000);
    for (int k = 1; k < 300; k++) begin
      st_data = 32'hC000_0000 + 32'(k) * 7; st_valid = 1'b1;
      do_read(2'd0, d);
      total++;
      if (d !== 32'hC000_0000 + 32'(k - 1) * 7) begin
        bad++; $display("FAIL stream%0d got=%h exp=%h", k, d, 32'hC000_0000 + 32'(k - 1) * 7);
      end
    end
    st_valid = 1'b0;
    do_read(2'd0, d);
    total++;
    if (d !== 32'hC000_0000 + 32'd299 * 7) begin bad++; $display("FAIL stream_last got=%h exp=%h", d, 32'hC000_0000 + 32'd299 * 7); end
    do_read(2'd2, d);
    total++;
    if (d !== 32'h01) begin bad++; $display("FAIL stream_status got=%h exp=01", d); end
  endtask

  task automatic test_flush();
    logic [31:0] d;
    for (int i = 0; i < 10; i++) do_push(32'h200 + i);
    st_data = 32'h2FF; st_valid = 1'b1;
    do_write(2'd3, 32'h1);
    st_valid = 1'b0;
    do_read(2'd1, d);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL flush_level got=%h exp=0", d); end
    do_read(2'd3, d);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL flush_ctrl_read got=%h exp=0", d); end
    do_read(2'd0, d);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL flush_pop got=%h exp=0", d); end
    do_read(2'd2, d);
    total++;
    if (d !== 32'h11) begin bad++; $display("FAIL flush_status got=%h exp=11", d); end
    do_write(2'd2, 32'h18);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    do_push(32'h31); do_push(32'h32); do_push(32'h33);
    reset = 1'b1;
    do_read(2'd0, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL midrst_data got=%h exp=0", d); end
    total++;
    if (st_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready got=%b exp=0", st_ready); end
    reset = 1'b0;
    do_read(2'd1, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL midrst_level got=%h exp=0", d); end
    do_read(2'd2, d);
    total++;
    if (d !== 32'h01) begin bad++; $display("FAIL midrst_status got=%h exp=01", d); end
  endtask

  task automatic test_irq();
`ifdef ST_FIFO_IRQ_EN
    logic [31:0] d;
    do_write(2'd3, 32'h2);
    do_read(2'd3, d);
    total++;
    if (d !== 32'h2) begin bad++; $display("FAIL irq_en_read got=%h exp=2", d); end
    for (int i = 0; i < 119; i++) do_push(32'h400 + i);
    @(negedge clk);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL irq_119 got=%b exp=0", irq); end
    do_push(32'h4FF);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL irq_lag got=%b exp=0", irq); end
    @(negedge clk);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL irq_120 got=%b exp=1", irq); end
    do_read(2'd0, d);
    @(negedge clk);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL irq_drain got=%b exp=0", irq); end
    do_push(32'h500);
    @(negedge clk);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL irq_refill got=%b exp=1", irq); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL irq_reset got=%b exp=0", irq); end
    do_read(2'd1, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL irq_reset_level got=%h exp=0", d); end
`endif
  endtask

  initial begin
    reset = 1'b1; st_data = '0; st_valid = 1'b0;
    mm_address = '0; mm_read = 1'b0; mm_write = 1'b0; mm_writedata = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_full();
    test_underflow();
    test_push_pop_same();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_irq();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
